// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N requesting channels, the arbiter/mux, and one downstream consumer.
interface rr_arb_mux_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned N_INPUTS = 4
) ();
  logic [N_INPUTS*WIDTH-1:0] in_data_i;
  logic [N_INPUTS-1:0]       in_valid_i;
  logic [N_INPUTS-1:0]       in_ready_o;
  logic [WIDTH-1:0]          out_data_o;
  logic [N_INPUTS-1:0]       out_sel_o;
  logic                      out_valid_o;
  logic                      out_ready_i;

  modport slave (
    input  in_data_i, in_valid_i, out_ready_i,
    output in_ready_o, out_data_o, out_sel_o, out_valid_o
  );

  modport master (
    output in_data_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_data_o, out_sel_o, out_valid_o
  );
endinterface

// File: rtl/rr_arb_mux.sv
// N-way arbiter (round-robin or fixed priority) feeding a single registered output slot
// that sustains one word per cycle when the consumer keeps accepting.
module rr_arb_mux #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned N_INPUTS      = 4,
  parameter int unsigned PRIORITY_MODE = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  rr_arb_mux_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(N_INPUTS);

  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [N_INPUTS-1:0] out_sel_q, out_sel_d;
  logic                out_valid_q, out_valid_d;

  logic [N_INPUTS-1:0] grant_c;
  logic [PTR_W-1:0]    grant_idx_c;
  logic                any_req_c;
  logic                load_c;
  logic                xfer_c;
  logic [WIDTH-1:0]    chan_data [N_INPUTS];

  for (genvar k = 0; k < N_INPUTS; k++) begin : g_chan
    assign chan_data[k] = bus.in_data_i[k*WIDTH +: WIDTH];
  end

  // Scan from ptr (or from 0 in fixed mode) and take the first requester.
  always_comb begin
    int unsigned idx;
    grant_c     = '0;
    grant_idx_c = '0;
    any_req_c   = 1'b0;
    idx         = 0;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      if (PRIORITY_MODE == 0) begin
        idx = 32'(ptr_q) + i;
        if (idx >= N_INPUTS) idx = idx - N_INPUTS;
      end else begin
        idx = i;
      end
      if (!any_req_c && bus.in_valid_i[PTR_W'(idx)]) begin
        any_req_c   = 1'b1;
        grant_idx_c = PTR_W'(idx);
      end
    end
    if (any_req_c) grant_c[grant_idx_c] = 1'b1;
  end

  assign load_c = !out_valid_q || bus.out_ready_i;
  assign xfer_c = load_c && any_req_c && !rst_i;

  assign bus.in_ready_o = (load_c && !rst_i) ? grant_c : '0;

  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (xfer_c) begin
      out_data_d  = chan_data[grant_idx_c];
      out_sel_d   = grant_c;
      out_valid_d = 1'b1;
      ptr_d       = (grant_idx_c == PTR_W'(N_INPUTS - 1)) ? '0 : grant_idx_c + PTR_W'(1);
    end else if (bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_data_o  = out_data_q;
  assign bus.out_sel_o   = out_sel_q;
  assign bus.out_valid_o = out_valid_q;
endmodule
